// File: rtl/icache_sa.sv
// Two-way set-associative instruction cache with 16-bit aligned (RVC) fetch.
// Lines are refilled word by word from memctrl. A 32-bit instruction that
// straddles two lines is assembled from both lines once both are resident.
module icache_sa #(
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        received,
    input  logic        memctrl_to_icache,
    input  logic [31:0] inst_in,
    output logic        icache_to_memctrl,
    output logic [31:0] address,
    input  logic        to_icache,
    input  logic [31:0] pc,
    input  logic        cancel,
    input  logic        clear,
    output logic        have_result,
    output logic [31:0] inst,
    output logic        is_c
);
    localparam int SETS   = 1 << INDEX_WIDTH;
    localparam int WORDS  = 1 << OFFSET_WIDTH;
    localparam int LINE_W = 32 - OFFSET_WIDTH - 2;
    localparam int TAG_W  = LINE_W - INDEX_WIDTH;

    localparam logic [OFFSET_WIDTH-1:0] OFF_LAST = '1;
    localparam logic [OFFSET_WIDTH-1:0] OFF_ONE  = OFFSET_WIDTH'(1);
    localparam logic [LINE_W-1:0]       LINE_ONE = LINE_W'(1);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    // Storage
    logic [TAG_W-1:0]   tag_mem  [2][SETS];
    logic [31:0]        data_mem [2][SETS][WORDS];
    logic [1:0][SETS-1:0] valid;
    logic [SETS-1:0]    lru;

    // Control state
    logic [0:0]              state;
    logic [OFFSET_WIDTH-1:0] k;
    logic                    req;
    logic [LINE_W-1:0]       fill_line;
    logic                    fill_way;
    logic                    fill_clear;

    logic [INDEX_WIDTH-1:0]  fill_idx;
    logic [TAG_W-1:0]        fill_tag;

    assign fill_idx = fill_line[INDEX_WIDTH-1:0];
    assign fill_tag = fill_line[LINE_W-1:INDEX_WIDTH];

    assign icache_to_memctrl = req;
    assign address           = {fill_line, k, 2'b00};

    // Lookup address decomposition
    logic [LINE_W-1:0]       line_a, line_b;
    logic [INDEX_WIDTH-1:0]  idx_a, idx_b;
    logic [TAG_W-1:0]        tag_a, tag_b;
    logic [OFFSET_WIDTH-1:0] off_a, off_next;
    logic                    unused_pc0;

    assign unused_pc0 = pc[0];
    assign line_a     = pc[31:OFFSET_WIDTH+2];
    assign line_b     = line_a + LINE_ONE;
    assign idx_a      = line_a[INDEX_WIDTH-1:0];
    assign tag_a      = line_a[LINE_W-1:INDEX_WIDTH];
    assign idx_b      = line_b[INDEX_WIDTH-1:0];
    assign tag_b      = line_b[LINE_W-1:INDEX_WIDTH];
    assign off_a      = pc[OFFSET_WIDTH+1:2];
    assign off_next   = off_a + OFF_ONE;

    logic hit_a0, hit_a1, hit_b0, hit_b1, hit_a, hit_b;
    logic way_a, way_b;

    assign hit_a0 = valid[0][idx_a] && (tag_mem[0][idx_a] == tag_a);
    assign hit_a1 = valid[1][idx_a] && (tag_mem[1][idx_a] == tag_a);
    assign hit_b0 = valid[0][idx_b] && (tag_mem[0][idx_b] == tag_b);
    assign hit_b1 = valid[1][idx_b] && (tag_mem[1][idx_b] == tag_b);
    assign hit_a  = hit_a0 || hit_a1;
    assign hit_b  = hit_b0 || hit_b1;
    assign way_a  = !hit_a0;
    assign way_b  = !hit_b0;

    logic [31:0] word_a;
    logic [15:0] half_next, half_b;

    assign word_a    = data_mem[way_a][idx_a][off_a];
    assign half_next = data_mem[way_a][idx_a][off_next][15:0];
    assign half_b    = data_mem[way_b][idx_b][0][15:0];

    logic [15:0]            half_lo, half_hi;
    logic                   compressed, need_b, hit;
    logic [31:0]            lookup_inst;
    logic [LINE_W-1:0]      tgt_line;
    logic [INDEX_WIDTH-1:0] tgt_idx;
    logic                   victim;

    // Instruction assembly, hit detection and refill victim selection
    always_comb begin
        half_lo    = pc[1] ? word_a[31:16] : word_a[15:0];
        compressed = (half_lo[1:0] != 2'b11);
        need_b     = pc[1] && (off_a == OFF_LAST) && !compressed;
        if (!pc[1])
            half_hi = word_a[31:16];
        else if (off_a != OFF_LAST)
            half_hi = half_next;
        else
            half_hi = half_b;
        lookup_inst = compressed ? {16'h0000, half_lo} : {half_hi, half_lo};
        hit         = hit_a && (!need_b || hit_b);

        // line A is refilled first; line B only once A is resident
        tgt_line = hit_a ? line_b : line_a;
        tgt_idx  = tgt_line[INDEX_WIDTH-1:0];
        if (!valid[0][tgt_idx])
            victim = 1'b0;
        else if (!valid[1][tgt_idx])
            victim = 1'b1;
        else
            victim = ~lru[tgt_idx];
    end

    // Line data and tag writes as refill words arrive
    always_ff @(posedge clk) begin
        if (!rst && rdy && state == S_REFILL && memctrl_to_icache) begin
            data_mem[fill_way][fill_idx][k] <= inst_in;
            if (k == OFF_LAST)
                tag_mem[fill_way][fill_idx] <= fill_tag;
        end
    end

    // Control FSM, valid/LRU bookkeeping and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            req         <= 1'b0;
            fill_line   <= '0;
            fill_way    <= 1'b0;
            fill_clear  <= 1'b0;
            have_result <= 1'b0;
            inst        <= '0;
            is_c        <= 1'b0;
            valid       <= '0;
            lru         <= '0;
        end else if (rdy) begin
            have_result <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        valid <= '0;
                    end else if (to_icache && !cancel && !have_result) begin
                        // The cycle that carries have_result still sees the
                        // answered pc, so it is not looked up a second time.
                        if (hit) begin
                            have_result <= 1'b1;
                            inst        <= lookup_inst;
                            is_c        <= compressed;
                            lru[idx_a]  <= way_a;
                            if (need_b)
                                lru[idx_b] <= way_b;
                        end else begin
                            state                   <= S_REFILL;
                            fill_line               <= tgt_line;
                            fill_way                <= victim;
                            fill_clear              <= 1'b0;
                            k                       <= '0;
                            req                     <= 1'b1;
                            valid[victim][tgt_idx]  <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (clear) begin
                        valid      <= '0;
                        fill_clear <= 1'b1;
                    end
                    if (received)
                        req <= 1'b0;
                    if (memctrl_to_icache) begin
                        if (k == OFF_LAST) begin
                            state <= S_IDLE;
                            req   <= 1'b0;
                            if (!fill_clear && !clear) begin
                                valid[fill_way][fill_idx] <= 1'b1;
                                lru[fill_idx]             <= fill_way;
                            end
                        end else begin
                            k   <= k + OFF_ONE;
                            req <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa with a one-word-per-cycle memctrl model.
module tb_icache_sa;
    logic        clk;
    logic        rst;
    logic        rdy;
    logic        received;
    logic        memctrl_to_icache;
    logic [31:0] inst_in;
    logic        icache_to_memctrl;
    logic [31:0] address;
    logic        to_icache;
    logic [31:0] pc;
    logic        cancel;
    logic        clear;
    logic        have_result;
    logic [31:0] inst;
    logic        is_c;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] served[$];

    icache_sa #(.INDEX_WIDTH(4), .OFFSET_WIDTH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .received          (received),
        .memctrl_to_icache (memctrl_to_icache),
        .inst_in           (inst_in),
        .icache_to_memctrl (icache_to_memctrl),
        .address           (address),
        .to_icache         (to_icache),
        .pc                (pc),
        .cancel            (cancel),
        .clear             (clear),
        .have_result       (have_result),
        .inst              (inst),
        .is_c              (is_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_010C: return 32'h0513_0093;
            32'h0000_0110: return 32'h1234_0000;
            32'h0000_0200: return 32'h0001_4501;
            default:       return {a[15:0], 16'h0003};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memctrl: answers a pending request within the same cycle
    initial begin
        received          = 1'b0;
        memctrl_to_icache = 1'b0;
        inst_in           = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst && rdy && icache_to_memctrl) begin
                received          = 1'b1;
                memctrl_to_icache = 1'b1;
                inst_in           = model_word(address);
                served.push_back(address);
            end else begin
                received          = 1'b0;
                memctrl_to_icache = 1'b0;
            end
        end
    end

    task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] got_inst,
                         output logic got_c, output int nreads);
        int   start;
        logic got;
        start     = served.size();
        got       = 1'b0;
        cyc       = 0;
        got_inst  = '0;
        got_c     = 1'b0;
        pc        = a;
        to_icache = 1'b1;
        while (!got && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (have_result) begin
                got      = 1'b1;
                got_inst = inst;
                got_c    = is_c;
            end
        end
        to_icache = 1'b0;
        nreads    = served.size() - start;
        check("fetch_timeout", {31'b0, got}, 32'd1);
        @(posedge clk);
        #1;
        check("pulse_width", {31'b0, have_result}, 32'd0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    logic [31:0] lru_addr [6] = '{32'h000, 32'h100, 32'h000, 32'h200, 32'h000, 32'h100};
    int          lru_cyc  [6] = '{6, 6, 1, 6, 1, 6};
    logic [31:0] lru_inst [6] = '{32'h3, 32'h13, 32'h3, 32'h4501, 32'h3, 32'h13};

    initial begin
        int          cyc, nreads, s, pulses;
        logic [31:0] ri;
        logic        rc;

        rst = 1'b1; rdy = 1'b1; to_icache = 1'b0; pc = '0; cancel = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_have_result", {31'b0, have_result}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_is_c", {31'b0, is_c}, 32'd0);
        check("rst_req", {31'b0, icache_to_memctrl}, 32'd0);
        check("rst_address", address, 32'd0);
        rst = 1'b0;

        // cold miss, then hit on the same line
        s = served.size();
        fetch(32'h100, cyc, ri, rc, nreads);
        check("cold_latency", cyc, 6);
        check("cold_inst", ri, 32'h0000_0013);
        check("cold_is_c", {31'b0, rc}, 32'd0);
        check("cold_reads", nreads, 4);
        for (int i = 0; i < 4; i++)
            check("cold_addr", served[s + i], 32'h100 + 32'(4 * i));
        fetch(32'h100, cyc, ri, rc, nreads);
        check("hit_latency", cyc, 1);
        check("hit_inst", ri, 32'h0000_0013);
        check("hit_reads", nreads, 0);

        // compressed halves of one word
        fetch(32'h200, cyc, ri, rc, nreads);
        check("c0_latency", cyc, 6);
        check("c0_inst", ri, 32'h0000_4501);
        check("c0_is_c", {31'b0, rc}, 32'd1);
        fetch(32'h202, cyc, ri, rc, nreads);
        check("c1_latency", cyc, 1);
        check("c1_inst", ri, 32'h0000_0001);
        check("c1_is_c", {31'b0, rc}, 32'd1);

        // clear, then a cross-line fetch with both lines cold
        pulse_clear();
        s = served.size();
        fetch(32'h10E, cyc, ri, rc, nreads);
        check("xl_latency", cyc, 11);
        check("xl_inst", ri, 32'h0000_0513);
        check("xl_is_c", {31'b0, rc}, 32'd0);
        check("xl_reads", nreads, 8);
        check("xl_addr_a", served[s], 32'h100);
        check("xl_addr_b", served[s + 4], 32'h110);
        fetch(32'h10E, cyc, ri, rc, nreads);
        check("xl_hit_latency", cyc, 1);
        check("xl_hit_inst", ri, 32'h0000_0513);

        // LRU replacement on set 0
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            fetch(lru_addr[i], cyc, ri, rc, nreads);
            check("lru_latency", cyc, lru_cyc[i]);
            check("lru_inst", ri, lru_inst[i]);
        end

        // cancel during refill: fill completes, no result
        s      = served.size();
        pulses = 0;
        pc        = 32'h020;
        to_icache = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (have_result) pulses++;
            if (i == 2) begin cancel = 1'b1; to_icache = 1'b0; end
            if (i == 3) cancel = 1'b0;
        end
        check("cancel_no_result", pulses, 0);
        check("cancel_reads", served.size() - s, 4);
        check("cancel_req_idle", {31'b0, icache_to_memctrl}, 32'd0);
        fetch(32'h020, cyc, ri, rc, nreads);
        check("cancel_hit_latency", cyc, 1);
        check("cancel_hit_inst", ri, 32'h0020_0003);

        // rdy low for three cycles during a refill
        s         = served.size();
        cyc       = 0;
        ri        = '0;
        pc        = 32'h030;
        to_icache = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= 3 && cyc <= 5) begin
                check("freeze_req", {31'b0, icache_to_memctrl}, 32'd1);
                check("freeze_addr", address, 32'h034);
            end
            if (cyc == 2) rdy = 1'b0;
            if (cyc == 5) rdy = 1'b1;
            if (have_result) begin
                ri = inst;
                break;
            end
        end
        to_icache = 1'b0;
        check("freeze_latency", cyc, 9);
        check("freeze_inst", ri, 32'h0030_0003);
        check("freeze_reads", served.size() - s, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/icache_sa.md
# icache_sa

Two-way set-associative, line-based instruction cache with RVC (16-bit aligned) fetch support, between ifetch and memctrl. Refills whole lines as a sequence of 32-bit word reads from memctrl and returns one instruction per request, with compressed instructions zero-extended. Supports lines that straddle a line boundary, LRU replacement, a full invalidate (fence.i) and request cancel on redirect.

## Interface
- INDEX_WIDTH, 4, log2 sets per way (16 sets).
- OFFSET_WIDTH, 2, log2 words per line (4 words = 16 bytes).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rdy  in  1  low = pause; all state and outputs hold.
- received  in  1  memctrl accepted current request.
- memctrl_to_icache  in  1  inst_in valid this cycle.
- inst_in  in  32  word read from memory.
- icache_to_memctrl  out  1  word-read request.
- address  out  32  word-aligned request address.
- to_icache  in  1  ifetch request; pc held stable until have_result or cancel.
- pc  in  32  fetch address, bit 0 always 0.
- cancel  in  1  ifetch abandons current request (redirect).
- clear  in  1  invalidate entire cache.
- have_result  out  1  one-cycle pulse, inst valid.
- inst  out  32  instruction; compressed = {16'b0, half}.
- is_c  out  1  inst is compressed (pc advance 2), valid with have_result.

## Operation
- Address split: offset = pc[OFFSET_WIDTH+1:0], index = next INDEX_WIDTH bits, tag = remaining upper bits. Per way per set: valid, tag, 2^OFFSET_WIDTH words; per set: 1 LRU bit (way most recently used).
- Lookup is combinational on pc: line A = line of pc. Cross-line case: pc[1]=1, word offset = last word of line, and low half at pc has bits[1:0]=2'b11 (32-bit); then line B = line A + line size is also needed.
- Hit: A hits, and B hits if needed. inst = concatenation of the halfwords at pc and pc+2 (or the low half only if compressed). Set LRU of each touched set to its hit way.
- States: IDLE, REFILL.
- IDLE: with to_icache and no cancel: on hit → have_result=1 next cycle; else pick the missing line (A first, then B), choose victim (invalid way 0, else invalid way 1, else ~LRU), go REFILL at word 0 of that line.
- REFILL: drive icache_to_memctrl=1, address=line base+4*k. On received, drop request next cycle. On memctrl_to_icache, write inst_in to word k of victim way; if k is last: write tag, set valid, update LRU, return to IDLE (lookup replays next cycle); else k+1 and re-raise request next cycle. received and memctrl_to_icache may coincide; the data counts and the request is re-raised for k+1 unless k was last.
- Valid is set only after the last word of a line; a partially filled line never hits.
- cancel: in IDLE, no response. In REFILL, the fill completes (memctrl transaction cannot be aborted), no have_result, return to IDLE.
- clear: in IDLE, all valid←0 next cycle and pending lookup is not served that cycle. In REFILL, the fill completes but the line stays invalid; all valid←0.
- A cross-line miss on both lines performs two consecutive refills before responding.
- rdy=0: nothing changes, memctrl inputs ignored; memctrl must also be paused.

## Timing
- Reset: state IDLE, all valid=0, all LRU=0, have_result=0, inst=0, is_c=0, icache_to_memctrl=0, address=0.
- Hit latency: to_icache sampled at edge N → have_result=1 during cycle N+1, deasserted N+2 unless a new hit.
- Miss latency: one edge to enter REFILL, 2^OFFSET_WIDTH word transactions, one edge to return to IDLE, then one lookup edge.
- have_result never asserted in REFILL; never two pulses for one request.
- Reset mid-REFILL: immediate return to reset state; memctrl is reset by the same rst.

## Test plan
- Cold miss pc=0x100, memctrl words 0x00000013.. at 0x100–0x10C, 1-cycle memctrl → 4 requests at 0x100,0x104,0x108,0x10C; have_result with inst=0x00000013, is_c=0; a repeat pc=0x100 hits in 1 cycle.
- Compressed: word at 0x200 = 0x00014501 → pc=0x200 gives inst=0x00004501, is_c=1; pc=0x202 gives 0x00000001, is_c=1.
- Cross-line: pc=0x10E, half 0x0513 at 0x10E, 0x0000 at 0x110, both lines cold → two refills (0x100, 0x110), inst=0x00000513.
- LRU: addresses 0x000, 0x100, 0x000 on the same set, then 0x200 → evicts 0x100's line; 0x000 still hits, 0x100 misses.
- clear after fill → next access to 0x100 misses. cancel asserted mid-refill → no have_result; a later access to that line hits.
- rdy low for 3 cycles mid-refill → request, address and counter frozen; completion delayed by exactly 3 cycles.
